// File: rtl/adder_serial_nbits.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, WIDTH/DIGIT cycles per
// operation, with ready/start/done handshake, carry/borrow and signed overflow.

// One-bit full adder cell; the digit adder is a ripple chain of these.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// Handshake: an operation is accepted on a rising edge where ready_o=1 and
// start_i=1; done_o pulses for one cycle on the edge that updates s_o/c_o/v_o,
// and ready_o is already high in that cycle so a new start can be accepted.
module adder_serial_nbits #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             c_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o,
  output logic             v_o,
  output logic             state_dbg_o
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  // Reject parameter sets that cannot be split into whole digits.
  if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("adder_serial_nbits: WIDTH must be a multiple of DIGIT and DIGIT >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_sub;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   r_s;
  logic               r_c;
  logic               r_v;

  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [DIGIT:0]     w_c;
  logic [DIGIT-1:0]   w_dsum;
  logic [WIDTH-1:0]   w_sum_next;

  // Ripple chain over the low digit of the operand registers.
  assign w_c[0] = r_carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a_i (r_x[i]),
      .b_i (r_y[i]),
      .c_i (w_c[i]),
      .s_o (w_dsum[i]),
      .c_o (w_c[i+1])
    );
  end

  // New digit enters at the top; after N digits the first digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_sum_single
    assign w_sum_next = w_dsum;
  end else begin : g_sum_multi
    assign w_sum_next = {w_dsum, r_sum[WIDTH-1:DIGIT]};
  end

  assign w_last = (r_cnt == CNT_W'(N - 1));

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand/sum shifting, carry, counter and registered results.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x     <= '0;
      r_y     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_s     <= '0;
      r_c     <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        // Subtract is x + ~y + ~borrow, so a borrow-in becomes a cleared carry.
        r_x     <= x_i;
        r_y     <= sub_i ? ~y_i : y_i;
        r_carry <= c_i ^ sub_i;
        r_sub   <= sub_i;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_x     <= r_x >> DIGIT;
        r_y     <= r_y >> DIGIT;
        r_sum   <= w_sum_next;
        r_carry <= w_c[DIGIT];
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_s    <= w_sum_next;
          r_c    <= w_c[DIGIT] ^ r_sub;
          r_v    <= w_c[DIGIT-1] ^ w_c[DIGIT];
          r_done <= 1'b1;
        end
      end
    end
  end

  assign ready_o     = (r_state == IDLE);
  assign done_o      = r_done;
  assign s_o         = r_s;
  assign c_o         = r_c;
  assign v_o         = r_v;
  assign state_dbg_o = r_state;

endmodule
